// File: rtl/pop.sv
// pop: TSMP framer arbitrating hcp/plc payload streams (i_clk, i_rst_n, hcp/plc data+valid->ready, hcp type) into ov_data/o_data_wr with MAC header and IFG
module pop #(
  parameter int DATA_WIDTH = 9,
  parameter logic [47:0] DMAC = 48'h0123_4567_89AB,
  parameter logic [47:0] SMAC = 48'h6655_4433_2211,
  parameter int IFG = 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [DATA_WIDTH-1:0] iv_data_hcp2pop,
  input  logic                  i_data_wr_hcp2pop,
  input  logic [7:0]            iv_type_hcp2pop,
  output logic                  o_ready_pop2hcp,
  input  logic [DATA_WIDTH-1:0] iv_data_plc2pop,
  input  logic                  i_data_wr_plc2pop,
  output logic                  o_ready_pop2plc,
  output logic [DATA_WIDTH-1:0] ov_data,
  output logic                  o_data_wr
);
  typedef enum logic [1:0] {IDLE, HEAD, BODY, GAP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [7:0] typ, hdr;
  logic last_hcp, g_hcp, first;
  logic hcp_req, plc_req, win_hcp, acc;
  logic [DATA_WIDTH-1:0] din;
  logic [31:0] dsh;
  logic [47:0] ssh;
  always_comb begin
    hcp_req = i_data_wr_hcp2pop & iv_data_hcp2pop[DATA_WIDTH-1];
    plc_req = i_data_wr_plc2pop & iv_data_plc2pop[DATA_WIDTH-1];
    win_hcp = hcp_req & (~plc_req | ~last_hcp);
    o_ready_pop2hcp = i_rst_n & (((state == IDLE) & i_data_wr_hcp2pop & ~iv_data_hcp2pop[DATA_WIDTH-1]) | ((state == BODY) & g_hcp));
    o_ready_pop2plc = i_rst_n & (((state == IDLE) & i_data_wr_plc2pop & ~iv_data_plc2pop[DATA_WIDTH-1]) | ((state == BODY) & ~g_hcp));
    din = g_hcp ? iv_data_hcp2pop : iv_data_plc2pop;
    acc = g_hcp ? i_data_wr_hcp2pop : i_data_wr_plc2pop;
    dsh = DMAC[31:0] << {cnt - 4'd2, 3'b000};
    ssh = SMAC << {cnt - 4'd6, 3'b000};
    hdr = cnt == 4'd1 ? typ : cnt < 4'd6 ? dsh[31:24] : cnt < 4'd12 ? ssh[47:40] : cnt == 4'd12 ? 8'hFF : 8'h01;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state <= IDLE;
      cnt <= 4'd0;
      typ <= 8'hFF;
      last_hcp <= 1'b0;
      g_hcp <= 1'b0;
      first <= 1'b0;
      ov_data <= '0;
      o_data_wr <= 1'b0;
    end else begin
      o_data_wr <= 1'b0;
      case (state)
        IDLE: if (hcp_req | plc_req) begin
          state <= HEAD;
          cnt <= 4'd1;
          g_hcp <= win_hcp;
          last_hcp <= win_hcp;
          typ <= win_hcp ? iv_type_hcp2pop : 8'h16;
          ov_data <= {1'b1, DMAC[47:40]};
          o_data_wr <= 1'b1;
        end
        HEAD: begin
          ov_data <= {1'b0, hdr};
          o_data_wr <= 1'b1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd13) begin
            state <= BODY;
            first <= 1'b1;
          end
        end
        BODY: if (acc) begin
          ov_data <= first ? {1'b0, din[7:0]} : din;
          o_data_wr <= 1'b1;
          first <= 1'b0;
          if (!first && din[DATA_WIDTH-1]) begin
            state <= GAP;
            cnt <= 4'd0;
          end
        end
        GAP: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'(IFG - 1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_pop.sv
// tb_pop: directed scoreboard bench for pop
module tb_pop;
  logic clk = 0, rst_n = 0;
  logic [8:0] hd = 0, pd = 0;
  logic hv = 0, pv = 0;
  logic [7:0] ht = 0;
  logic hr, pr, wr;
  logic [8:0] od;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [8:0] d; int k;} exp_t;
  exp_t q[$];
  exp_t cur;
  int gaps[$];
  int idle = 0, fgap = 0, bad_rdy = 0;
  bit seen_tail = 0, watch = 0;
  logic [8:0] f1[$] = '{9'h1F0, 9'h022, 9'h033, 9'h144};
  logic [8:0] f2[$] = '{9'h1AA, 9'h0BB, 9'h1CC};
  logic [8:0] fab[$] = '{9'h101, 9'h102};
  logic [8:0] ha[$] = '{9'h110, 9'h011, 9'h112};
  logic [8:0] pb[$] = '{9'h120, 9'h021, 9'h022, 9'h123};
  logic [8:0] pc[$] = '{9'h130, 9'h031, 9'h032, 9'h033, 9'h134};
  logic [8:0] hdd[$] = '{9'h140, 9'h141};
  logic [8:0] he[$] = '{9'h150, 9'h051, 9'h152};
  logic [8:0] pf[$] = '{9'h160, 9'h061, 9'h162};
  logic [8:0] hg[$] = '{9'h170, 9'h071, 9'h072, 9'h173};
  logic [8:0] ph[$] = '{9'h180, 9'h181};

  pop dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .iv_data_hcp2pop(hd), .i_data_wr_hcp2pop(hv), .iv_type_hcp2pop(ht), .o_ready_pop2hcp(hr),
    .iv_data_plc2pop(pd), .i_data_wr_plc2pop(pv), .o_ready_pop2plc(pr),
    .ov_data(od), .o_data_wr(wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_frame(input logic [7:0] t, input logic [8:0] w[$]);
    logic [7:0] h[14] = '{8'h01, 8'h00, 8'h45, 8'h67, 8'h89, 8'hAB, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'hFF, 8'h01};
    h[1] = t;
    for (int i = 0; i < 14; i++) q.push_back('{{i == 0, h[i]}, i == 0 ? 1 : 0});
    for (int i = 0; i < w.size(); i++)
      q.push_back('{i == 0 ? {1'b0, w[i][7:0]} : w[i], i == w.size() - 1 ? 2 : 0});
  endfunction

  task automatic send(input bit h, input logic [7:0] t, input logic [8:0] w[$], input int gap_at = -1);
    if (h) ht = t;
    for (int i = 0; i < w.size(); i++) begin
      int n = 0;
      if (h) begin hv = 1; hd = w[i]; end else begin pv = 1; pd = w[i]; end
      @(negedge clk);
      while (!(h ? hr : pr) && n < 2000) begin @(negedge clk); n++; end
      if (n >= 2000) begin
        chk("send_timeout", 32'(n), 0);
        if (h) hv = 0; else pv = 0;
        return;
      end
      @(posedge clk); #1;
      if (h) hv = 0; else pv = 0;
      if (i == gap_at) begin repeat (3) @(posedge clk); #1; end
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 3000) begin @(negedge clk); #1; n++; end
    chk({tag, "_drain"}, 32'(q.size()), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (watch && hr) bad_rdy++;
    if (!rst_n) begin
      idle = 0;
      seen_tail = 0;
    end else if (!wr) idle++;
    else if (q.size() == 0) chk("spurious_wr", 32'(wr), 0);
    else begin
      cur = q.pop_front();
      chk("out", 32'(od), 32'(cur.d));
      if (cur.k == 1) begin
        if (seen_tail) chk("ifg_ok", 32'(idle >= 2), 1);
        fgap = 0;
      end else fgap += idle;
      idle = 0;
      if (cur.k == 2) begin
        gaps.push_back(fgap);
        seen_tail = 1;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    hv = 1; hd = 9'h055;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov_data", 32'(od), 0);
    chk("rst_wr", 32'(wr), 0);
    chk("rst_rdy_hcp", 32'(hr), 0);
    chk("rst_rdy_plc", 32'(pr), 0);
    hv = 0; rst_n = 1;
    @(posedge clk); #1;
    push_frame(8'h00, f1);
    send(1, 8'h00, f1);
    drain("basic");
    hv = 1; hd = 9'h055;
    @(negedge clk);
    chk("discard_rdy", 32'(hr), 1);
    chk("discard_nowr", 32'(wr), 0);
    @(posedge clk); #1;
    hv = 0;
    push_frame(8'h5A, f2);
    send(1, 8'h5A, f2);
    drain("after_discard");
    push_frame(8'h00, fab);
    while (q.size() > 8) void'(q.pop_back());
    ht = 8'h00; hv = 1; hd = 9'h101;
    n = 0;
    while (q.size() != 0 && n < 100) begin @(negedge clk); #1; n++; end
    chk("abort_hdr7", 32'(q.size()), 0);
    rst_n = 0; hv = 0;
    #1;
    chk("abort_wr", 32'(wr), 0);
    chk("abort_ov", 32'(od), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    push_frame(8'h01, ha);
    push_frame(8'h16, pb);
    fork
      send(1, 8'h01, ha);
      send(0, 8'h00, pb);
    join
    drain("tie");
    gaps.delete();
    push_frame(8'h16, pc);
    push_frame(8'h07, hdd);
    fork
      begin send(0, 8'h00, pc, 1); watch = 0; end
      begin repeat (20) @(posedge clk); #1; watch = 1; send(1, 8'h07, hdd); end
    join
    drain("plc_gap");
    chk("gap_frames", 32'(gaps.size()), 2);
    chk("gap_plc", 32'(gaps[0]), 3);
    chk("gap_hcp", 32'(gaps[1]), 0);
    chk("hcp_rdy_held", 32'(bad_rdy), 0);
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    @(posedge clk); #1;
    push_frame(8'h01, he);
    push_frame(8'h16, pf);
    push_frame(8'h00, hg);
    push_frame(8'h16, ph);
    fork
      begin send(1, 8'h01, he); send(1, 8'h00, hg); end
      begin send(0, 8'h00, pf); send(0, 8'h00, ph); end
    join
    drain("b2b");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
